// File: rtl/mod_updown_counter_pkg.sv
// rtl/mod_updown_counter_pkg.sv - shared legality checks and sizing helpers for mod_updown_counter
//
// Contents:
//   dir_e         count direction, taken straight from the up input
//   width_ok      WIDTH in 1..32
//   modulus_ok    MODULUS in 2..2**WIDTH
//   prescale_ok   PRESCALE in 1..256
//   saturate_ok   SATURATE is 0 or 1
//   presc_width   bits needed for a prescaler counter holding 0..PRESCALE-1
package mod_updown_counter_pkg;

    typedef enum logic [0:0] {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic bit width_ok(input int w);
        return (w >= 1) && (w <= 32);
    endfunction

    // 2**WIDTH reaches 2**32, so the bound is built in 64 bits.
    function automatic bit modulus_ok(input int w, input longint m);
        return (m >= 2) && (m <= (longint'(1) << w));
    endfunction

    function automatic bit prescale_ok(input int p);
        return (p >= 1) && (p <= 256);
    endfunction

    function automatic bit saturate_ok(input int s);
        return (s == 0) || (s == 1);
    endfunction

    // A PRESCALE of 1 still gets a 1-bit counter; it simply stays at 0.
    function automatic int presc_width(input int p);
        return (p <= 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/mod_updown_counter_tick_prescaler.sv
// rtl/mod_updown_counter_tick_prescaler.sv - enable-gated divide-by-PRESCALE tick generator
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset, counter to 0
//   en       advances the counter; the counter holds while low
//   restart  synchronous restart of the interval (clear or load in the parent)
//   tick     high in an en cycle where the counter sits at PRESCALE-1
module tick_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // Combinational so the parent can register the step in the same edge.
    assign tick = en && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo up/down counter with prescaler, load, clear, wrap/saturate and sticky overflow
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   en        count enable, gates prescaler and stepping
//   up        1 = increment, 0 = decrement
//   clear     synchronous clear of count and prescaler (ovf untouched)
//   load      load load_val (clamped to MODULUS-1) into count
//   load_val  value to load
//   ovf_clr   clears the sticky ovf flag
//   count     registered count, 0..MODULUS-1
//   tc        registered one-cycle pulse after each boundary event
//   ovf       registered sticky boundary-crossing flag
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = 0,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $fatal(1, "mod_updown_counter: WIDTH must be 1..32");
        end
        if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
            $fatal(1, "mod_updown_counter: MODULUS must be 2..2**WIDTH");
        end
        if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
            $fatal(1, "mod_updown_counter: PRESCALE must be 1..256");
        end
        if (!saturate_ok(SATURATE)) begin : g_bad_saturate
            $fatal(1, "mod_updown_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam bit               SAT     = (SATURATE != 0);

    dir_e             dir;
    logic             tick;
    logic             step;
    logic             at_top;
    logic             at_bot;
    logic             boundary;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    assign dir = dir_e'(up);

    // Clear and load both restart the interval so the next step is a full
    // PRESCALE enabled cycles away.
    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(clear | load),
        .tick   (tick)
    );

    // tick already includes en; clear and load outrank a step.
    assign step     = tick && !clear && !load;
    assign at_top   = (count == MAX_VAL);
    assign at_bot   = (count == '0);
    assign boundary = step && ((dir == DIR_UP) ? at_top : at_bot);

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        step_val = count;
        if (dir == DIR_UP) begin
            if (at_top) begin
                step_val = SAT ? count : '0;
            end else begin
                step_val = count + WIDTH'(1);
            end
        end else begin
            if (at_bot) begin
                step_val = SAT ? count : MAX_VAL;
            end else begin
                step_val = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= boundary;
            // A boundary event in the same cycle as ovf_clr keeps the flag set.
            if (boundary) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_clamped;
            end else if (step) begin
                count <= step_val;
            end
        end
    end

endmodule
